// File: rtl/otp_ctrl.sv
// OTP/eFuse sequencer: LOAD copies OTP bytes into the register file, PROGRAM burns
// register-file bytes into OTP one set bit at a time. Operations start only when I2C is idle.
module otp_ctrl #(
  parameter int unsigned N_BYTES = 16,
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_RD    = 3,
  parameter int unsigned T_PGM   = 8,
  parameter int unsigned T_HD    = 1,
  parameter int unsigned T_VQ    = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       i_i2c_busy,
  input  logic       i_run_test_mode,
  output logic       o_otp_vddqsw,
  output logic       o_otp_csb,
  output logic       o_otp_strobe,
  output logic       o_otp_load,
  input  logic [7:0] i_otp_q,
  output logic [9:0] o_otp_addr,
  output logic       o_otp_pgenb,
  output logic [7:0] o_xbus_din,
  output logic [6:0] o_xbus_addr,
  input  logic [7:0] i_xbus_dout,
  input  logic       i_otp_read_n,
  input  logic       i_otp_prog
);

  typedef enum logic [3:0] {
    StIdle, StRdSetup, StRdStrobe, StRdWrite, StPgVq,
    StPgFetch, StPgSetup, StPgStrobe, StPgHold, StDone
  } state_e;

  localparam logic [6:0] IdleAddr = 7'h7F;
  localparam logic [6:0] LastByte = 7'(N_BYTES - 1);
  // Byte index one past the end marks the PROGRAM tail cycle (csb/pgenb released, vddqsw on).
  localparam logic [6:0] TailByte = 7'(N_BYTES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       load_pend_q, load_pend_d;
  logic       prog_pend_q, prog_pend_d;
  logic       boot_q, boot_d;
  logic       prog_s1, prog_s2, read_s1, read_s2;
  logic       load_edge, prog_edge, load_req, prog_req;
  logic [3:0] nxt;

  logic       csb_d, pgenb_d, strobe_d, load_d, vddqsw_d;
  logic [9:0] otp_addr_d;
  logic [6:0] xbus_addr_d;
  logic [7:0] xbus_din_d;

  // Lowest set bit of data at or above index from; 8 means none left.
  function automatic logic [3:0] next_one(input logic [7:0] data, input logic [3:0] from);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (data[i] && (4'(i) >= from)) idx = 4'(i);
    end
    return idx;
  endfunction

  assign load_edge = ~read_s1 & read_s2 & i_run_test_mode;
  assign prog_edge = prog_s1 & ~prog_s2 & i_run_test_mode;
  assign load_req  = load_pend_q | load_edge | (boot_q & ~i_run_test_mode);
  assign prog_req  = prog_pend_q | prog_edge;

  // Request synchronisers and FSM state registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_s1     <= 1'b0;
      prog_s2     <= 1'b0;
      read_s1     <= 1'b1;
      read_s2     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      byte_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      load_pend_q <= 1'b0;
      prog_pend_q <= 1'b0;
      boot_q      <= 1'b1;
    end else begin
      prog_s1     <= i_otp_prog;
      prog_s2     <= prog_s1;
      read_s1     <= i_otp_read_n;
      read_s2     <= read_s1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      load_pend_q <= load_pend_d;
      prog_pend_q <= prog_pend_d;
      boot_q      <= boot_d;
    end
  end

  // Next-state logic: request arbitration and per-byte/per-bit sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    byte_d      = byte_q;
    bit_d       = bit_q;
    data_d      = data_q;
    load_pend_d = load_pend_q;
    prog_pend_d = prog_pend_q;
    boot_d      = boot_q;
    nxt         = 4'd0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_i2c_busy) begin
          load_pend_d = load_pend_q | load_edge;
          prog_pend_d = prog_req;
        end else begin
          boot_d = 1'b0;
          load_pend_d = 1'b0;
          prog_pend_d = prog_req;
          byte_d = '0;
          bit_d = '0;
          if (load_req) begin
            state_d = StRdSetup;
          end else if (prog_req) begin
            prog_pend_d = 1'b0;
            state_d = StPgVq;
          end
        end
      end
      StRdSetup: begin
        if (cnt_q == 8'(T_SU - 1)) begin
          state_d = StRdStrobe;
          cnt_d = '0;
        end
      end
      StRdStrobe: begin
        if (cnt_q == 8'(T_RD - 1)) begin
          data_d = i_otp_q;
          state_d = StRdWrite;
          cnt_d = '0;
        end
      end
      StRdWrite: begin
        // First cycle is the register-file write, the rest is address hold.
        if (cnt_q == 8'(T_HD)) begin
          cnt_d = '0;
          if (byte_q == LastByte) begin
            state_d = StDone;
          end else begin
            byte_d = byte_q + 7'd1;
            state_d = StRdSetup;
          end
        end
      end
      StPgVq: begin
        if (cnt_q == 8'(T_VQ - 1)) begin
          state_d = StPgFetch;
          cnt_d = '0;
        end
      end
      StPgFetch: begin
        if (byte_q == TailByte) begin
          state_d = StDone;
        end else if (cnt_q == 8'd1) begin
          data_d = i_xbus_dout;
          nxt = next_one(i_xbus_dout, 4'd0);
          cnt_d = '0;
          if (!nxt[3]) begin
            bit_d = nxt[2:0];
            state_d = StPgSetup;
          end else begin
            byte_d = byte_q + 7'd1;
          end
        end
      end
      StPgSetup: begin
        if (cnt_q == 8'(T_SU - 1)) begin
          state_d = StPgStrobe;
          cnt_d = '0;
        end
      end
      StPgStrobe: begin
        if (cnt_q == 8'(T_PGM - 1)) begin
          state_d = StPgHold;
          cnt_d = '0;
        end
      end
      StPgHold: begin
        if (cnt_q == 8'(T_HD - 1)) begin
          nxt = next_one(data_q, {1'b0, bit_q} + 4'd1);
          cnt_d = '0;
          if (!nxt[3]) begin
            bit_d = nxt[2:0];
            state_d = StPgSetup;
          end else begin
            byte_d = byte_q + 7'd1;
            state_d = StPgFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output is a glitch-free flop aligned with state
  always_comb begin
    csb_d       = 1'b1;
    pgenb_d     = 1'b1;
    strobe_d    = 1'b0;
    load_d      = 1'b0;
    vddqsw_d    = 1'b0;
    otp_addr_d  = '0;
    xbus_addr_d = IdleAddr;
    xbus_din_d  = '0;
    unique case (state_d)
      StRdSetup, StRdStrobe, StRdWrite: begin
        csb_d      = 1'b0;
        load_d     = 1'b1;
        strobe_d   = (state_d == StRdStrobe);
        otp_addr_d = {byte_d, 3'b000};
        if (state_d == StRdWrite && cnt_d == 8'd0) begin
          xbus_addr_d = byte_d;
          xbus_din_d  = data_d;
        end
      end
      StPgVq: begin
        csb_d    = 1'b0;
        pgenb_d  = 1'b0;
        vddqsw_d = 1'b1;
      end
      StPgFetch: begin
        vddqsw_d = 1'b1;
        if (byte_d != TailByte) begin
          csb_d       = 1'b0;
          pgenb_d     = 1'b0;
          xbus_addr_d = byte_d;
        end
      end
      StPgSetup, StPgStrobe, StPgHold: begin
        csb_d      = 1'b0;
        pgenb_d    = 1'b0;
        vddqsw_d   = 1'b1;
        strobe_d   = (state_d == StPgStrobe);
        otp_addr_d = {byte_d, bit_d};
      end
      default: ;
    endcase
  end

  // Output registers; asynchronous reset drives the macro to its safe state at once
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_otp_csb    <= 1'b1;
      o_otp_pgenb  <= 1'b1;
      o_otp_strobe <= 1'b0;
      o_otp_load   <= 1'b0;
      o_otp_vddqsw <= 1'b0;
      o_otp_addr   <= '0;
      o_xbus_addr  <= IdleAddr;
      o_xbus_din   <= '0;
    end else begin
      o_otp_csb    <= csb_d;
      o_otp_pgenb  <= pgenb_d;
      o_otp_strobe <= strobe_d;
      o_otp_load   <= load_d;
      o_otp_vddqsw <= vddqsw_d;
      o_otp_addr   <= otp_addr_d;
      o_xbus_addr  <= xbus_addr_d;
      o_xbus_din   <= xbus_din_d;
    end
  end

endmodule

// File: tb/tb_otp_ctrl.sv
// Directed bench for otp_ctrl: auto-load, PROGRAM, busy gating, arbitration, zero data, reset.
module tb_otp_ctrl;
  localparam int NB   = 16;
  localparam int TRD  = 3;
  localparam int TPGM = 8;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i2c_busy = 1'b0;
  logic       test_mode = 1'b0;
  logic       read_n = 1'b1;
  logic       prog = 1'b0;
  logic [7:0] prog_data = 8'h66;
  logic       otp_vddqsw, otp_csb, otp_strobe, otp_load, otp_pgenb;
  logic [9:0] otp_addr;
  logic [7:0] otp_q, xbus_din, xbus_dout;
  logic [6:0] xbus_addr;

  int checks = 0;
  int passed = 0;

  // Stats filled by observe_op
  int n_strobe, width_err, wr_cnt, wr_err, fetch_cnt, fetch_err, vq_err, conflict, addr_err;
  int dup_err, load_seen, pg_seen;
  logic [7:0] mask [128];

  always #5 sys_clk = ~sys_clk;

  otp_ctrl dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .i_i2c_busy     (i2c_busy),
    .i_run_test_mode(test_mode),
    .o_otp_vddqsw   (otp_vddqsw),
    .o_otp_csb      (otp_csb),
    .o_otp_strobe   (otp_strobe),
    .o_otp_load     (otp_load),
    .i_otp_q        (otp_q),
    .o_otp_addr     (otp_addr),
    .o_otp_pgenb    (otp_pgenb),
    .o_xbus_din     (xbus_din),
    .o_xbus_addr    (xbus_addr),
    .i_xbus_dout    (xbus_dout),
    .i_otp_read_n   (read_n),
    .i_otp_prog     (prog)
  );

  // OTP content per byte address
  function automatic logic [7:0] otp_val(input logic [6:0] b);
    return (8'(b) * 8'h1D) ^ 8'hA5;
  endfunction

  assign otp_q     = (otp_strobe && otp_load) ? otp_val(otp_addr[9:3]) : 8'h00;
  assign xbus_dout = (xbus_addr != 7'h7F) ? prog_data : 8'h00;

  // Watch one operation from csb falling until csb high with vddqsw low
  task automatic observe_op(input int budget, output bit started, output bit ended);
    int run;
    logic prev_s;
    logic [9:0] prev_a;
    logic [6:0] prev_x;
    n_strobe = 0; width_err = 0; wr_cnt = 0; wr_err = 0; fetch_cnt = 0; fetch_err = 0;
    vq_err = 0; conflict = 0; addr_err = 0; dup_err = 0; load_seen = 0; pg_seen = 0;
    for (int i = 0; i < 128; i++) mask[i] = 8'h00;
    started = 1'b0;
    ended = 1'b0;
    run = 0;
    prev_s = 1'b0;
    prev_x = 7'h7F;
    for (int i = 0; i < budget && !started; i++) begin
      @(negedge sys_clk);
      if (!otp_csb) started = 1'b1;
    end
    prev_a = otp_addr;
    for (int i = 0; i < budget && started && !ended; i++) begin
      if (otp_csb && !otp_vddqsw) begin
        ended = 1'b1;
      end else begin
        if (!otp_pgenb) pg_seen = 1;
        if (otp_load) load_seen = 1;
        if (!otp_pgenb && otp_load) conflict++;
        if (otp_strobe) begin
          if (!prev_s) n_strobe++;
          run++;
          if (otp_addr != prev_a) addr_err++;
          if (!otp_pgenb) begin
            if (!otp_vddqsw) vq_err++;
            if (!prev_s) begin
              if (mask[otp_addr[9:3]][otp_addr[2:0]]) dup_err++;
              mask[otp_addr[9:3]][otp_addr[2:0]] = 1'b1;
            end
          end
        end else if (prev_s) begin
          if (run != (otp_load ? TRD : TPGM)) width_err++;
          run = 0;
        end
        if (otp_load && xbus_addr != 7'h7F) begin
          if (xbus_addr != 7'(wr_cnt) || xbus_din != otp_val(7'(wr_cnt))) wr_err++;
          wr_cnt++;
        end
        if (!otp_load && xbus_addr != 7'h7F && xbus_addr != prev_x) begin
          if (xbus_addr != 7'(fetch_cnt)) fetch_err++;
          fetch_cnt++;
        end
        prev_s = otp_strobe;
        prev_a = otp_addr;
        prev_x = xbus_addr;
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic test_reset();
    test_mode = 1'b0;
    i2c_busy = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (otp_csb !== 1'b1) $display("FAIL reset_csb: got %b want 1", otp_csb); else passed++;
    checks++; if (otp_pgenb !== 1'b1) $display("FAIL reset_pgenb: got %b want 1", otp_pgenb); else passed++;
    checks++; if (otp_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", otp_strobe); else passed++;
    checks++; if (otp_load !== 1'b0) $display("FAIL reset_load: got %b want 0", otp_load); else passed++;
    checks++; if (otp_vddqsw !== 1'b0) $display("FAIL reset_vddqsw: got %b want 0", otp_vddqsw); else passed++;
    checks++; if (otp_addr !== 10'h000) $display("FAIL reset_otp_addr: got %h want 000", otp_addr); else passed++;
    checks++; if (xbus_addr !== 7'h7F) $display("FAIL reset_xbus_addr: got %h want 7f", xbus_addr); else passed++;
    checks++; if (xbus_din !== 8'h00) $display("FAIL reset_xbus_din: got %h want 00", xbus_din); else passed++;
  endtask

  task automatic test_autoload();
    bit st, en;
    @(negedge sys_clk);
    rst_n = 1'b1;
    observe_op(400, st, en);
    checks++; if (st !== 1'b1) $display("FAIL auto_start: got %b want 1", st); else passed++;
    checks++; if (en !== 1'b1) $display("FAIL auto_end: got %b want 1", en); else passed++;
    checks++; if (n_strobe !== NB) $display("FAIL auto_strobes: got %0d want %0d", n_strobe, NB); else passed++;
    checks++; if (width_err !== 0) $display("FAIL auto_width: got %0d bad want 0", width_err); else passed++;
    checks++; if (wr_cnt !== NB) $display("FAIL auto_writes: got %0d want %0d", wr_cnt, NB); else passed++;
    checks++; if (wr_err !== 0) $display("FAIL auto_write_data: got %0d bad want 0", wr_err); else passed++;
    checks++; if (pg_seen !== 0) $display("FAIL auto_pgenb: got %0d want 0", pg_seen); else passed++;
    checks++; if (addr_err !== 0) $display("FAIL auto_addr_stable: got %0d want 0", addr_err); else passed++;
  endtask

  task automatic test_program();
    bit st, en;
    int bad;
    rst_n = 1'b0;
    test_mode = 1'b1;
    i2c_busy = 1'b1;
    prog = 1'b0;
    prog_data = 8'h66;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    i2c_busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (otp_csb !== 1'b1) $display("FAIL test_mode_idle: got csb %b want 1", otp_csb); else passed++;
    prog = 1'b1;
    observe_op(2000, st, en);
    bad = 0;
    for (int b = 0; b < NB; b++) if (mask[b] != 8'h66) bad++;
    checks++; if (en !== 1'b1) $display("FAIL prog_end: got %b want 1", en); else passed++;
    checks++; if (n_strobe !== 4 * NB) $display("FAIL prog_strobes: got %0d want %0d", n_strobe, 4 * NB); else passed++;
    checks++; if (bad !== 0) $display("FAIL prog_bits: got %0d bytes wrong want 0", bad); else passed++;
    checks++; if (dup_err !== 0) $display("FAIL prog_dup: got %0d want 0", dup_err); else passed++;
    checks++; if (width_err !== 0) $display("FAIL prog_width: got %0d bad want 0", width_err); else passed++;
    checks++; if (vq_err !== 0) $display("FAIL prog_vddqsw: got %0d want 0", vq_err); else passed++;
    checks++; if (load_seen !== 0) $display("FAIL prog_load: got %0d want 0", load_seen); else passed++;
    checks++; if (conflict !== 0) $display("FAIL prog_conflict: got %0d want 0", conflict); else passed++;
    checks++; if (addr_err !== 0) $display("FAIL prog_addr_stable: got %0d want 0", addr_err); else passed++;
    checks++; if (fetch_cnt !== NB) $display("FAIL prog_fetches: got %0d want %0d", fetch_cnt, NB); else passed++;
  endtask

  task automatic test_busy_block();
    bit st, en;
    int act;
    prog = 1'b0;
    repeat (3) @(negedge sys_clk);
    i2c_busy = 1'b1;
    prog = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (!otp_csb) act++;
    end
    checks++; if (act !== 0) $display("FAIL busy_blocks: got %0d active cycles want 0", act); else passed++;
    i2c_busy = 1'b0;
    observe_op(2000, st, en);
    checks++; if (st !== 1'b1) $display("FAIL busy_release_start: got %b want 1", st); else passed++;
    checks++; if (n_strobe !== 4 * NB) $display("FAIL busy_prog_strobes: got %0d want %0d", n_strobe, 4 * NB); else passed++;
    act = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (!otp_csb) act++;
    end
    checks++; if (act !== 0) $display("FAIL prog_held_retrigger: got %0d active cycles want 0", act); else passed++;
  endtask

  task automatic test_both();
    bit st, en;
    prog = 1'b0;
    read_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    prog = 1'b1;
    read_n = 1'b0;
    observe_op(400, st, en);
    checks++; if (load_seen !== 1 || pg_seen !== 0) $display("FAIL both_first_is_load: got load %0d pg %0d want 1 0", load_seen, pg_seen); else passed++;
    checks++; if (wr_cnt !== NB) $display("FAIL both_load_writes: got %0d want %0d", wr_cnt, NB); else passed++;
    checks++; if (wr_err !== 0) $display("FAIL both_load_data: got %0d bad want 0", wr_err); else passed++;
    observe_op(2000, st, en);
    checks++; if (st !== 1'b1 || pg_seen !== 1) $display("FAIL both_second_is_prog: got start %b pg %0d want 1 1", st, pg_seen); else passed++;
    checks++; if (n_strobe !== 4 * NB) $display("FAIL both_prog_strobes: got %0d want %0d", n_strobe, 4 * NB); else passed++;
    read_n = 1'b1;
    prog = 1'b0;
  endtask

  task automatic test_zero_data();
    bit st, en;
    prog_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    prog = 1'b1;
    observe_op(2000, st, en);
    checks++; if (en !== 1'b1) $display("FAIL zero_end: got %b want 1", en); else passed++;
    checks++; if (n_strobe !== 0) $display("FAIL zero_strobes: got %0d want 0", n_strobe); else passed++;
    checks++; if (fetch_cnt !== NB) $display("FAIL zero_fetches: got %0d want %0d", fetch_cnt, NB); else passed++;
    checks++; if (fetch_err !== 0) $display("FAIL zero_walk: got %0d bad want 0", fetch_err); else passed++;
    prog = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit;
    int act;
    prog_data = 8'h66;
    repeat (3) @(negedge sys_clk);
    prog = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge sys_clk);
      if (otp_strobe && !otp_pgenb) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) $display("FAIL mid_reach_strobe: got %b want 1", hit); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (otp_strobe !== 1'b0) $display("FAIL mid_rst_strobe: got %b want 0", otp_strobe); else passed++;
    checks++; if (otp_vddqsw !== 1'b0) $display("FAIL mid_rst_vddqsw: got %b want 0", otp_vddqsw); else passed++;
    checks++; if (otp_csb !== 1'b1) $display("FAIL mid_rst_csb: got %b want 1", otp_csb); else passed++;
    checks++; if (otp_pgenb !== 1'b1) $display("FAIL mid_rst_pgenb: got %b want 1", otp_pgenb); else passed++;
    prog = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    act = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (!otp_csb || otp_vddqsw) act++;
    end
    checks++; if (act !== 0) $display("FAIL mid_no_resume: got %0d active cycles want 0", act); else passed++;
  endtask

  initial begin
    test_reset();
    test_autoload();
    test_program();
    test_busy_block();
    test_both();
    test_zero_data();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
